vblank_scheduler: RTL and testbench
===================================

Name: vblank_scheduler

Overview:
- Controller that shares the vertical-blank window between game-logic engines (player, enemies, bullets, score) so that game state updates only while no pixels are being drawn.
- Monitors the display timing position (x, y, pixel tick) and detects vblank entry and exit.
- During vblank, grants exclusive update access to one requester at a time using round-robin order, with a per-grant timeout.
- Sits between the display timing generator and the game-logic engines, in the fast clk domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- V_ACTIVE, 480, first non-visible line; vblank entry occurs at y==V_ACTIVE.
- TIMEOUT, 1024, maximum clk cycles a grant may be held without done.
- TW, 11, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- p_tick  in  1  one-clk-wide pixel-advance enable.
- x  in  10  current pixel column.
- y  in  10  current pixel line.
- req  in  N_REQ  per-engine update request (level).
- done  in  N_REQ  per-engine completion strobe.
- clear_err  in  1  clears the sticky error flags.
- grant  out  N_REQ  one-hot exclusive update grant.
- frame_tick  out  1  one-cycle pulse at vblank entry.
- in_vblank  out  1  high from vblank entry to vblank exit.
- busy  out  1  high while any grant is active.
- overrun  out  1  one-cycle pulse when vblank ends with a grant active.
- timeout_err  out  N_REQ  sticky flag per requester, set on grant timeout.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0.
  - State IDLE, rr_ptr=0, served=0, timer=0.
- Event detection (registered):
  - entry = p_tick && x==0 && y==V_ACTIVE.
  - exit = p_tick && x==0 && y==0.
  - frame_tick and in_vblank rise one cycle after entry.
  - in_vblank falls one cycle after exit.
- States: IDLE, SELECT, GRANT, CLOSE.
- IDLE:
  - On entry: served=0, go to SELECT.
  - All req ignored.
- SELECT (one cycle):
  - pending = req & ~served.
  - If pending==0, go to CLOSE.
  - Otherwise pick the first set bit of pending, searching from rr_ptr upward with wrap.
  - grant[i] asserts the next cycle and the FSM enters GRANT with timer=0.
  - Grant latency from the SELECT cycle is 1 cycle.
- GRANT:
  - grant held constant; timer increments each cycle.
  - done[i] for the granted i: served[i]=1, rr_ptr=(i+1) mod N_REQ, grant deasserts next cycle, go to SELECT.
  - done on a non-granted bit is ignored.
  - req[i] falling while granted has no effect; grant holds until done or timeout.
  - timer==TIMEOUT-1 with no done: timeout_err[i]=1, served[i]=1, rr_ptr advances as above, grant drops, go to SELECT.
- CLOSE: wait for exit, then go to IDLE.
- exit while in GRANT or SELECT:
  - grant drops next cycle; go to IDLE.
  - overrun pulses if state was GRANT.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, no error.
  - done and exit in the same cycle: served, go to IDLE, no overrun.
  - entry while not IDLE (malformed timing): ignored.
- grant is always one-hot or zero; at most one grant per requester per vblank.
- busy = |grant.
- timeout_err:
  - clear_err clears it the next cycle.
  - A set in the same cycle as clear_err wins.
- rr_ptr persists across frames, giving cross-frame fairness.

Decomposition:
- starsoc_params package holds:
  - V_ACTIVE and the timeout constants.
  - sched_state_t enum {IDLE, SELECT, GRANT, CLOSE}.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: pending[N_REQ], ptr.
  - Outputs: idx, valid.
  - Instantiated once.

Test Plan:
- Reset mid-grant:
  - Stimulus: assert reset low while grant=0010.
  - Required: all outputs 0 immediately; after release, the next vblank grants starting from req bit 0.
- Basic round-robin:
  - Stimulus: req=1111, each done 5 cycles after its grant.
  - Required: grant order 0001, 0010, 0100, 1000, then CLOSE; frame_tick exactly once.
- Cross-frame fairness:
  - Stimulus: req=0011; vblank ends after only bit0 is served (bit1 granted, overrun=1).
  - Required: next frame, grant 0010 first.
- Timeout:
  - Stimulus: req=0100, done never asserted.
  - Required: grant drops after exactly 1024 cycles; timeout_err=0100 and stays set until clear_err.
- Simultaneous events:
  - Stimulus: done[i] in the same cycle as exit.
  - Required: overrun=0, served, IDLE.
  - Stimulus: done on a non-granted bit.
  - Required: grant unchanged.
- Empty vblank:
  - Stimulus: req=0000 at entry.
  - Required: SELECT then CLOSE; grant never asserts; in_vblank high from line 480 until y wraps to 0.

Source files
------------

// File: rtl/starsoc_params.sv
// Shared constants and FSM state type for the vblank update scheduler.
// Defaults match a 640x480 raster with a 1024-cycle grant limit.
package starsoc_params;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_TIMEOUT  = 1024;
  localparam int DEF_TW       = 11;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    GRANT,
    CLOSE
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of pending,
// searching upward from ptr with wrap-around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  localparam int SW = PW + 1;

  logic [SW-1:0] w_sum;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = |pending;
    w_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + SW'(k);
      if (w_sum >= SW'(N_REQ))
        w_sum = w_sum - SW'(N_REQ);
      if (pending[w_sum[PW-1:0]])
        idx = w_sum[PW-1:0];
    end
  end

endmodule

// File: rtl/vblank_scheduler.sv
// Shares the vertical-blank window between game-logic engines with
// round-robin exclusive grants and a per-grant timeout.
module vblank_scheduler
  import starsoc_params::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TW       = DEF_TW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_tick,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             clear_err,
  output logic [N_REQ-1:0] grant,
  output logic             frame_tick,
  output logic             in_vblank,
  output logic             busy,
  output logic             overrun,
  output logic [N_REQ-1:0] timeout_err
);

  localparam int PW = $clog2(N_REQ);

  sched_state_t     r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]    r_gidx, w_gidx_nxt;
  logic [N_REQ-1:0] r_served, w_served_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic [N_REQ-1:0] r_err, w_err_set;
  logic             r_overrun, w_overrun_nxt;
  logic             r_frame, r_vblank;

  logic             w_entry, w_exit;
  logic [N_REQ-1:0] w_pending;
  logic [PW-1:0]    w_idx, w_ptr_adv;
  logic             w_valid, w_done, w_tmo;

  assign w_entry = p_tick && (x == 10'd0) && (y == 10'(V_ACTIVE));
  assign w_exit  = p_tick && (x == 10'd0) && (y == 10'd0);

  assign w_pending = req & ~r_served;
  assign w_done    = |(done & r_grant);
  assign w_tmo     = (r_timer == TW'(TIMEOUT - 1));
  assign w_ptr_adv = (r_gidx == PW'(N_REQ - 1)) ? '0
                                                : r_gidx + PW'(1);

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .pending (w_pending),
    .ptr     (r_ptr),
    .idx     (w_idx),
    .valid   (w_valid)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_gidx_nxt    = r_gidx;
    w_served_nxt  = r_served;
    w_ptr_nxt     = r_ptr;
    w_timer_nxt   = r_timer;
    w_err_set     = '0;
    w_overrun_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_entry) begin
          w_served_nxt = '0;
          w_state_nxt  = SELECT;
        end
      end
      SELECT: begin
        if (w_exit) begin
          w_state_nxt = IDLE;
        end else if (!w_valid) begin
          w_state_nxt = CLOSE;
        end else begin
          w_grant_nxt = N_REQ'(1) << w_idx;
          w_gidx_nxt  = w_idx;
          w_timer_nxt = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_timer_nxt = r_timer + TW'(1);
        // done beats both timeout and exit; exit beats timeout
        if (w_done || (w_tmo && !w_exit)) begin
          w_served_nxt = r_served | r_grant;
          w_ptr_nxt    = w_ptr_adv;
          w_grant_nxt  = '0;
          w_err_set    = w_done ? '0 : r_grant;
          w_state_nxt  = w_exit ? IDLE : SELECT;
        end else if (w_exit) begin
          w_grant_nxt   = '0;
          w_overrun_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      CLOSE: begin
        if (w_exit)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_served  <= '0;
      r_ptr     <= '0;
      r_timer   <= '0;
      r_err     <= '0;
      r_overrun <= 1'b0;
      r_frame   <= 1'b0;
      r_vblank  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_gidx    <= w_gidx_nxt;
      r_served  <= w_served_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timer   <= w_timer_nxt;
      r_err     <= (clear_err ? '0 : r_err) | w_err_set;
      r_overrun <= w_overrun_nxt;
      r_frame   <= w_entry && (r_state == IDLE);
      if (w_entry)
        r_vblank <= 1'b1;
      else if (w_exit)
        r_vblank <= 1'b0;
    end
  end

  assign grant       = r_grant;
  assign busy        = |r_grant;
  assign frame_tick  = r_frame;
  assign in_vblank   = r_vblank;
  assign overrun     = r_overrun;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Scoreboard bench for vblank_scheduler: a frame-level model predicts
// the grant sequence; a monitor checks each grant as it ends.
module tb_vblank_scheduler;

  localparam int N    = 4;
  localparam int NEVR = 2000;

  logic         clk = 1'b0;
  logic         reset;
  logic         p_tick;
  logic [9:0]   x, y;
  logic [N-1:0] req, done, done_auto, done_man;
  logic         clear_err;
  logic [N-1:0] grant, timeout_err;
  logic         frame_tick, in_vblank, busy, overrun;

  assign done = done_auto | done_man;

  always #5 clk = ~clk;

  vblank_scheduler #(
    .N_REQ    (4),
    .V_ACTIVE (480),
    .TIMEOUT  (1024),
    .TW       (11)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .p_tick      (p_tick),
    .x           (x),
    .y           (y),
    .req         (req),
    .done        (done),
    .clear_err   (clear_err),
    .grant       (grant),
    .frame_tick  (frame_tick),
    .in_vblank   (in_vblank),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int idx;
    int dur;
  } exp_t;

  exp_t         exp_q[$];
  int           dly[N];
  int           m_ptr;
  logic [N-1:0] m_err;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           ft_cnt = 0;
  int           ov_cnt = 0;
  int           cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Frame model: req is steady, engines answer after dly[] cycles;
  // grant number `cut` (if >= 0) is truncated by vblank exit.
  task automatic plan(input logic [N-1:0] rq, input int cut,
                      output int span);
    int n, start, i, d;
    bit stop;
    n = 0;
    span = 0;
    stop = 0;
    start = m_ptr;
    for (int k = 0; k < N; k++) begin
      i = (start + k) % N;
      if (rq[i] && !stop) begin
        if (n == cut) begin
          exp_q.push_back('{i, -1});
          stop = 1;
        end else begin
          d = (dly[i] >= 1024) ? 1024 : dly[i] + 1;
          exp_q.push_back('{i, d});
          if (dly[i] >= 1024) m_err[i] = 1'b1;
          m_ptr = (i + 1) % N;
          span += d + 2;
          n++;
        end
      end
    end
  endtask

  task automatic do_entry();
    @(negedge clk);
    p_tick = 1'b1; x = 10'd0; y = 10'd480;
    @(negedge clk);
    p_tick = 1'b0; x = 10'd1;
  endtask

  task automatic do_exit();
    @(negedge clk);
    p_tick = 1'b1; x = 10'd0; y = 10'd0;
    @(negedge clk);
    p_tick = 1'b0; x = 10'd1;
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string nm);
    for (int k = 0; k < 20 && grant != g; k++) @(negedge clk);
    chk(nm, grant, g);
  endtask

  task automatic run_frame(input logic [N-1:0] rq, input int cut,
                           input int len, input int exp_ov);
    int span, ft0, ov0;
    req = rq;
    plan(rq, cut, span);
    if (len <= 0) len = span + 12;
    ft0 = ft_cnt;
    ov0 = ov_cnt;
    do_entry();
    repeat (2) @(negedge clk);
    chk("in_vblank_hi", in_vblank, 1);
    repeat (len) @(negedge clk);
    do_exit();
    repeat (4) @(negedge clk);
    chk("in_vblank_lo", in_vblank, 0);
    chk("frame_tick_cnt", ft_cnt - ft0, 1);
    chk("overrun_cnt", ov_cnt - ov0, exp_ov);
    chk("timeout_err", timeout_err, m_err);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_err = '0;
    chk("err_cleared", timeout_err, 0);
  endtask

  // Monitor: checks every grant when it ends against the scoreboard.
  logic [N-1:0] prev_g = '0;
  int           g_start = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (frame_tick) ft_cnt++;
    if (overrun) ov_cnt++;
    chk("busy", busy, |grant);
    chk("onehot", $onehot0(grant), 1);
    if (grant != 0 && prev_g == 0)
      g_start = cyc;
    else if (grant != 0 && grant != prev_g)
      chk("grant_stable", grant, prev_g);
    if (grant == 0 && prev_g != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", prev_g, 0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_idx", prev_g, 1 << e.idx);
        if (e.dur >= 0) chk("grant_len", cyc - g_start, e.dur);
      end
    end
    prev_g = grant;
  end

  // Engine responder: answers its own grant after dly[] cycles.
  initial begin : resp
    int ri, rk;
    done_auto = '0;
    forever begin
      @(negedge clk);
      if (grant != 0) begin
        ri = $clog2(grant);
        rk = 0;
        while (rk < dly[ri] && grant[ri]) begin
          @(negedge clk);
          rk++;
        end
        if (grant[ri]) begin
          done_auto[ri] = 1'b1;
          @(negedge clk);
          done_auto = '0;
        end
        rk = 0;
        while (grant != 0 && rk < 2000) begin
          @(negedge clk);
          rk++;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int span, ft0, ov0, r;
    logic [N-1:0] rq;
    reset = 1'b0;
    p_tick = 1'b0; x = 10'd1; y = 10'd0;
    req = '0; done_man = '0; clear_err = 1'b0;
    m_ptr = 0; m_err = '0;
    for (int i = 0; i < N; i++) dly[i] = 5;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {grant, frame_tick, in_vblank, busy, overrun, timeout_err}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(4'b1111, -1, 0, 0);

    dly[1] = NEVR;
    run_frame(4'b0011, 1, 100, 1);
    dly[1] = 5;
    run_frame(4'b0011, -1, 0, 0);

    dly[2] = NEVR;
    run_frame(4'b0100, -1, 0, 0);
    repeat (40) @(negedge clk);
    chk("err_sticky", timeout_err, 4'b0100);
    pulse_clear();
    dly[2] = 5;

    dly[3] = 1023;
    run_frame(4'b1000, -1, 0, 0);
    dly[3] = 5;

    // done in the same cycle as exit
    dly[0] = NEVR;
    req = 4'b0001;
    exp_q.push_back('{0, 4});
    m_ptr = 1;
    ov0 = ov_cnt;
    do_entry();
    wait_grant(4'b0001, "wait_grant0");
    repeat (3) @(negedge clk);
    done_man = 4'b0001;
    p_tick = 1'b1; x = 10'd0; y = 10'd0;
    @(negedge clk);
    done_man = '0;
    p_tick = 1'b0; x = 10'd1;
    repeat (4) @(negedge clk);
    chk("done_exit_ovr", ov_cnt - ov0, 0);
    chk("done_exit_vb", in_vblank, 0);
    chk("done_exit_sb", exp_q.size(), 0);
    dly[0] = 5;
    run_frame(4'b0011, -1, 0, 0);

    // done strobes on engines that do not hold the grant
    dly[0] = 20;
    req = 4'b0001;
    plan(4'b0001, -1, span);
    do_entry();
    wait_grant(4'b0001, "wait_grant_ng");
    repeat (5) @(negedge clk);
    done_man = 4'b1110;
    @(negedge clk);
    done_man = '0;
    chk("grant_hold", grant, 4'b0001);
    repeat (40) @(negedge clk);
    do_exit();
    repeat (4) @(negedge clk);
    chk("ng_done_sb", exp_q.size(), 0);
    chk("ng_done_err", timeout_err, 0);

    // reset while engine 1 holds the grant
    for (int i = 0; i < N; i++) dly[i] = 50;
    req = 4'b0110;
    exp_q.push_back('{1, -1});
    do_entry();
    wait_grant(4'b0010, "pre_rst_grant");
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_mid_outs",
           {grant, frame_tick, in_vblank, busy, overrun, timeout_err}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    m_err = '0;
    repeat (2) @(negedge clk);
    chk("rst_mid_sb", exp_q.size(), 0);
    for (int i = 0; i < N; i++) dly[i] = 3;
    run_frame(4'b1111, -1, 0, 0);

    run_frame(4'b0000, -1, 40, 0);

    for (int f = 0; f < 12; f++) begin
      rq = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 15);
        dly[i] = (r == 0) ? NEVR : (r == 1) ? 1023 : $urandom_range(0, 40);
      end
      run_frame(rq, -1, 0, 0);
      if ($urandom_range(0, 2) == 0) pulse_clear();
    end

    repeat (5) @(negedge clk);
    chk("final_sb", exp_q.size(), 0);
    chk("final_idle", grant, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
